// File: rtl/plot_writer_pkg.sv
// Shared constants, types and address helper for the plot_writer pixel path.
package plot_writer_pkg;
    localparam int XMAX    = 160;
    localparam int YMAX    = 120;
    localparam int FB_AW   = 15;
    localparam int COLOR_W = 3;
    localparam int X_W     = 8;
    localparam int Y_W     = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [COLOR_W-1:0] color;
    } pix_t;

    // y*160 + x without a multiplier: 160 = 128 + 32.
    function automatic logic [FB_AW-1:0] fb_addr_of(input logic [Y_W-1:0] y,
                                                   input logic [X_W-1:0] x);
        return (FB_AW'(y) << 7) + (FB_AW'(y) << 5) + FB_AW'(x);
    endfunction
endpackage

// File: rtl/plot_writer_fifo.sv
// Synchronous show-ahead FIFO holding pending pixel strobes; a push into a full
// FIFO is accepted only when a pop happens in the same cycle.
module plot_fifo
    import plot_writer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = $bits(pix_t)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && (!full || pop);
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/plot_writer.sv
// Buffers processor pixel strobes and drains them as handshaked framebuffer
// writes; also sweeps the whole screen with a fill color on request.
module plot_writer #(
    parameter int DEPTH = 8,
    parameter int XMAX  = 160,
    parameter int YMAX  = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  xpos,
    input  logic [6:0]  ypos,
    input  logic [2:0]  color,
    input  logic        plot,
    input  logic        clear_req,
    input  logic [2:0]  clear_color,
    input  logic        fb_ready,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [2:0]  fb_data,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        clear_done
);
    import plot_writer_pkg::*;

    localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(XMAX * YMAX - 1);

    state_e               state_q;
    logic                 fb_we_q;
    logic [FB_AW-1:0]     fb_addr_q;
    logic [COLOR_W-1:0]   fb_data_q;
    logic                 clear_done_q;
    logic                 clr_pend_q;
    logic [COLOR_W-1:0]   clr_color_q;
    logic                 overflow_q, overflow_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;

    pix_t                 in_pix, head;
    logic                 in_range, full, empty;
    logic                 push, pop, xfer, reg_free, clr_go;
    logic [FB_AW-1:0]     head_addr;
    logic [COLOR_W-1:0]   clr_fill;

    plot_fifo #(.DEPTH(DEPTH), .W($bits(pix_t))) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_pix),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        in_pix    = '{x: xpos, y: ypos, color: color};
        in_range  = (32'(xpos) < XMAX) && (32'(ypos) < YMAX);
        xfer      = fb_we_q && fb_ready;
        reg_free  = !fb_we_q || fb_ready;
        // A clear request parks further pops until the output register drains.
        clr_go    = (state_q != ST_CLEAR) && (clear_req || clr_pend_q);
        pop       = (state_q != ST_CLEAR) && !clr_go && !empty && reg_free;
        push      = plot && in_range && (!full || pop);
        head_addr = fb_addr_of(head.y, head.x);
        clr_fill  = clear_req ? clear_color : clr_color_q;

        overflow_d = overflow_q || (plot && in_range && full && !pop);
        drop_cnt_d = drop_cnt_q;
        if (plot && !in_range && drop_cnt_q != 8'hFF)
            drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            clear_done_q <= 1'b0;
            clr_pend_q   <= 1'b0;
            clr_color_q  <= '0;
        end else begin
            clear_done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DRAIN: begin
                    if (clr_go && reg_free) begin
                        state_q    <= ST_CLEAR;
                        clr_pend_q <= 1'b0;
                        fb_we_q    <= 1'b1;
                        fb_addr_q  <= '0;
                        fb_data_q  <= clr_fill;
                        clr_color_q <= clr_fill;
                    end else begin
                        if (clear_req) begin
                            clr_pend_q  <= 1'b1;
                            clr_color_q <= clear_color;
                        end
                        if (pop) begin
                            state_q   <= ST_DRAIN;
                            fb_we_q   <= 1'b1;
                            fb_addr_q <= head_addr;
                            fb_data_q <= head.color;
                        end else begin
                            if (xfer) fb_we_q <= 1'b0;
                            state_q <= (empty && reg_free && !clr_go) ? ST_IDLE : ST_DRAIN;
                        end
                    end
                end
                ST_CLEAR: begin
                    // The output address register doubles as the sweep counter.
                    if (xfer) begin
                        if (fb_addr_q == FB_LAST) begin
                            fb_we_q      <= 1'b0;
                            clear_done_q <= 1'b1;
                            state_q      <= empty ? ST_IDLE : ST_DRAIN;
                        end else begin
                            fb_addr_q <= fb_addr_q + FB_AW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    fb_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = !empty || fb_we_q || clr_pend_q || (state_q == ST_CLEAR);
endmodule

// File: tb/tb_plot_writer.sv
// Randomized self-checking bench for plot_writer: scoreboard of expected
// framebuffer writes plus simple counters for drops, overflow and clears.
module tb_plot_writer;
    localparam int DEPTH = 8;
    localparam int XMAX  = 160;
    localparam int YMAX  = 120;
    localparam int NPIX  = XMAX * YMAX;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  xpos = '0;
    logic [6:0]  ypos = '0;
    logic [2:0]  color = '0;
    logic        plot = 1'b0;
    logic        clear_req = 1'b0;
    logic [2:0]  clear_color = '0;
    logic        fb_ready = 1'b1;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clear_done;

    plot_writer #(.DEPTH(DEPTH), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk(clk), .reset(reset), .xpos(xpos), .ypos(ypos), .color(color),
        .plot(plot), .clear_req(clear_req), .clear_color(clear_color),
        .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .busy(busy), .overflow(overflow), .drop_cnt(drop_cnt), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0, n_err = 0;
    int  exp_drop = 0;
    int  exp_ovf = 0;
    int  n_wr = 0;
    bit  in_clear = 0;
    int  clr_idx = 0, clr_col_e = 0, done_cnt = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: every accepted write is scored; stalled outputs must hold.
    initial begin : monitor
        bit p_valid = 0, p_we = 0, p_rdy = 0;
        int p_addr = 0, p_data = 0;
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (p_valid && p_we && !p_rdy) begin
                    chk("hold_we", int'(fb_we), 1);
                    chk("hold_addr", int'(fb_addr), p_addr);
                    chk("hold_data", int'(fb_data), p_data);
                end
                if (fb_we && fb_ready) begin
                    if (in_clear) begin
                        chk("clr_addr", int'(fb_addr), clr_idx);
                        chk("clr_data", int'(fb_data), clr_col_e);
                        clr_idx++;
                    end else if (exp_q.size() == 0) begin
                        chk("spurious_wr", int'(fb_addr), -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", int'(fb_addr), e.addr);
                        chk("wr_data", int'(fb_data), e.data);
                        n_wr++;
                    end
                end
                if (clear_done) begin
                    done_cnt++;
                    in_clear = 0;
                end
                p_valid = 1; p_we = fb_we; p_rdy = fb_ready;
                p_addr = int'(fb_addr); p_data = int'(fb_data);
            end else begin
                p_valid = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one plot strobe; the model records it if it is in range and q=1.
    task automatic do_plot(input int x, input int y, input int c, input bit q);
        wr_t e;
        xpos = 8'(x); ypos = 7'(y); color = 3'(c); plot = 1'b1;
        if (x >= XMAX || y >= YMAX) begin
            if (exp_drop < 255) exp_drop++;
        end else if (q) begin
            e.addr = y * XMAX + x;
            e.data = c;
            exp_q.push_back(e);
        end
        step();
        plot = 1'b0;
    endtask

    task automatic wait_idle(input bit tog);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (tog) fb_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1;
            else step();
        end
        if (!done) chk("idle_timeout", 0, 1);
        fb_ready = 1'b1;
        step();
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_queue", exp_q.size(), 0);
        step();
    endtask

    task automatic single_plot_test(input string tag);
        do_plot(10, 5, 4, 1);
        @(negedge clk);
        chk({tag, "_lat_we0"}, int'(fb_we), 0);
        @(negedge clk);
        chk({tag, "_lat_we1"}, int'(fb_we), 1);
        chk({tag, "_addr"}, int'(fb_addr), 810);
        chk({tag, "_data"}, int'(fb_data), 4);
        step();
        wait_idle(0);
    endtask

    initial begin : main
        int base, x, y;
        bit ok;
        reset = 1'b0;
        fb_ready = 1'b1;
        repeat (2) step();
        @(negedge clk);
        chk("rst_we", int'(fb_we), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_data", int'(fb_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        chk("rst_done", int'(clear_done), 0);
        step();
        reset = 1'b1;
        step();

        single_plot_test("single");

        // Corner pixel and the two just-out-of-range plots.
        do_plot(159, 119, 7, 1);
        do_plot(160, 0, 1, 1);
        do_plot(0, 120, 1, 1);
        wait_idle(0);
        chk("corner_drop", int'(drop_cnt), exp_drop);
        chk("corner_ovf", int'(overflow), 0);

        // Stalled burst: the FIFO plus the output register hold DEPTH+1.
        fb_ready = 1'b0;
        base = n_wr;
        for (int i = 0; i < 10; i++)
            do_plot($urandom_range(0, XMAX-1), $urandom_range(0, YMAX-1),
                    $urandom_range(0, 7), i < DEPTH + 1);
        exp_ovf = 1;
        repeat (3) step();
        @(negedge clk);
        chk("stall_we", int'(fb_we), 1);
        chk("stall_ovf", int'(overflow), exp_ovf);
        chk("stall_busy", int'(busy), 1);
        step();
        fb_ready = 1'b1;
        wait_idle(0);
        chk("stall_written", n_wr - base, DEPTH + 1);

        // Burst of 4 with a toggling ready.
        for (int i = 0; i < 4; i++) begin
            fb_ready = 1'(i & 1);
            do_plot($urandom_range(0, XMAX-1), $urandom_range(0, YMAX-1),
                    $urandom_range(0, 7), 1);
        end
        wait_idle(1);

        // Random traffic; in-range plots are held back when the FIFO could be full.
        for (int i = 0; i < 400; i++) begin
            fb_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 7) == 0) begin
                    x = $urandom_range(0, 255);
                    y = $urandom_range(YMAX, 127);
                    do_plot(x, y, $urandom_range(0, 7), 1);
                end else if (exp_q.size() < DEPTH) begin
                    do_plot($urandom_range(0, XMAX-1), $urandom_range(0, YMAX-1),
                            $urandom_range(0, 7), 1);
                end else step();
            end else step();
        end
        wait_idle(1);
        chk("rand_drop", int'(drop_cnt), exp_drop);
        chk("rand_ovf", int'(overflow), exp_ovf);

        // Full clear with a plot issued mid-sweep.
        in_clear = 1; clr_idx = 0; clr_col_e = 2; done_cnt = 0;
        clear_color = 3'd2; clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        repeat (1000) step();
        do_plot(33, 44, 5, 1);
        ok = 0;
        for (int i = 0; i < 25000 && !ok; i++) begin
            step();
            if (done_cnt > 0) ok = 1;
        end
        chk("clear_finished", int'(ok), 1);
        repeat (3) step();
        chk("clear_done_pulses", done_cnt, 1);
        chk("clear_count", clr_idx, NPIX);
        wait_idle(0);

        // Reset in the middle of a sweep.
        in_clear = 1; clr_idx = 0; clr_col_e = $urandom_range(0, 7);
        clear_color = 3'(clr_col_e); clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            if (clr_idx >= 500) ok = 1;
        end
        chk("mid_clear_reached", int'(ok), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        in_clear = 0; exp_ovf = 0; exp_drop = 0;
        exp_q.delete();
        @(negedge clk);
        chk("rst2_we", int'(fb_we), 0);
        chk("rst2_busy", int'(busy), 0);
        chk("rst2_ovf", int'(overflow), 0);
        chk("rst2_drop", int'(drop_cnt), 0);
        repeat (5) step();
        @(negedge clk);
        chk("rst2_quiet", int'(fb_we), 0);
        step();
        single_plot_test("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
